// File: rtl/safety_boot_ctrl_pkg.sv
// rtl/safety_boot_ctrl_pkg.sv - shared types and register map for the safety boot controller
package safety_boot_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT_JTAG      = 2'd0,
        BOOT_PRELOADED = 2'd1,
        BOOT_RSVD2     = 2'd2,
        BOOT_RSVD3     = 2'd3
    } bootmode_e;

    typedef enum logic [1:0] {
        SEQ_RESET_WAIT,
        SEQ_AUTO_DELAY,
        SEQ_RUN,
        SEQ_DONE
    } seq_state_e;

    localparam logic [3:0] OFF_BOOTADDR    = 4'h0;
    localparam logic [3:0] OFF_FETCHEN     = 4'h4;
    localparam logic [3:0] OFF_CORESTATUS  = 4'h8;
    localparam logic [3:0] GLOBAL_HART_IDX = 4'hF;
    localparam logic [7:0] ADDR_EOCMASK    = 8'hF0;
    localparam logic [7:0] ADDR_IRQEN      = 8'hF4;

endpackage

// File: rtl/safety_boot_ctrl_hart_regs.sv
// rtl/safety_boot_ctrl_hart_regs.sv - per-hart BOOTADDR, FETCHEN and CORESTATUS registers
module safety_boot_ctrl_hart_regs #(
    parameter logic [31:0] DefaultBootAddr = 32'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_bootaddr_i,
    input  logic        we_fetchen_i,
    input  logic        we_status_i,
    input  logic [31:0] wdata_i,
    input  logic        auto_en_i,
    output logic [31:0] boot_addr_o,
    output logic        fetch_en_o,
    output logic [31:0] status_o
);

    logic [31:0] boot_addr_q, boot_addr_d;
    logic        fetch_en_q, fetch_en_d;
    logic [31:0] status_q, status_d;

    // A software FETCHEN write overrides the sequencer's automatic enable.
    always_comb begin
        boot_addr_d = boot_addr_q;
        fetch_en_d  = fetch_en_q;
        status_d    = status_q;
        if (we_bootaddr_i) boot_addr_d = wdata_i;
        if (we_fetchen_i)  fetch_en_d  = wdata_i[0];
        else if (auto_en_i) fetch_en_d = 1'b1;
        if (we_status_i)   status_d    = wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            boot_addr_q <= DefaultBootAddr;
            fetch_en_q  <= 1'b0;
            status_q    <= '0;
        end else begin
            boot_addr_q <= boot_addr_d;
            fetch_en_q  <= fetch_en_d;
            status_q    <= status_d;
        end
    end

    assign boot_addr_o = boot_addr_q;
    assign fetch_en_o  = fetch_en_q;
    assign status_o    = status_q;

endmodule

// File: rtl/safety_boot_ctrl.sv
// rtl/safety_boot_ctrl.sv - boot sequencer, register interface and EOC aggregation for multiple harts
module safety_boot_ctrl
    import safety_boot_ctrl_pkg::*;
#(
    parameter int unsigned NumHarts        = 2,
    parameter logic [31:0] DefaultBootAddr = 32'h0001_0000,
    parameter int unsigned AutoBootDelay   = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [1:0]                   bootmode_i,
    input  logic                         reg_req_i,
    input  logic                         reg_we_i,
    input  logic [7:0]                   reg_addr_i,
    input  logic [31:0]                  reg_wdata_i,
    output logic                         reg_ready_o,
    output logic [31:0]                  reg_rdata_o,
    output logic                         reg_error_o,
    output logic [NumHarts-1:0][31:0]    boot_addr_o,
    output logic [NumHarts-1:0]          fetch_en_o,
    output logic                         eoc_o,
    output logic                         exit_fail_o,
    output logic                         eoc_irq_o
);

    localparam logic [15:0] DelayLast = 16'(AutoBootDelay - 1);

    logic [3:0]          hart_idx, reg_off;
    logic                acc_err, wr_ok, auto_en;
    logic [NumHarts-1:0] hart_wr, status_eoc, code_nz;
    logic [31:0]         status [NumHarts];

    logic        ready_q, ready_d, error_q, error_d, irqen_q, irqen_d;
    logic        eoc_prev_q, irq_q, irq_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] cnt_q, cnt_d;
    seq_state_e  state_q, state_d;

    assign hart_idx = reg_addr_i[7:4];
    assign reg_off  = reg_addr_i[3:0];

    always_comb begin
        acc_err = 1'b0;
        if (reg_addr_i[1:0] != 2'b00) begin
            acc_err = 1'b1;
        end else if (hart_idx == GLOBAL_HART_IDX) begin
            acc_err = !((reg_addr_i == ADDR_EOCMASK && !reg_we_i) || reg_addr_i == ADDR_IRQEN);
        end else if ({28'd0, hart_idx} >= NumHarts) begin
            acc_err = 1'b1;
        end else begin
            acc_err = (reg_off == 4'hC);
        end
    end

    assign wr_ok = reg_req_i && reg_we_i && !acc_err;

    for (genvar h = 0; h < NumHarts; h++) begin : g_hart
        assign hart_wr[h] = wr_ok && (hart_idx == 4'(h));

        safety_boot_ctrl_hart_regs #(
            .DefaultBootAddr(DefaultBootAddr)
        ) u_regs (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .we_bootaddr_i(hart_wr[h] && reg_off == OFF_BOOTADDR),
            .we_fetchen_i (hart_wr[h] && reg_off == OFF_FETCHEN),
            .we_status_i  (hart_wr[h] && reg_off == OFF_CORESTATUS),
            .wdata_i      (reg_wdata_i),
            .auto_en_i    (auto_en && (h == 0)),
            .boot_addr_o  (boot_addr_o[h]),
            .fetch_en_o   (fetch_en_o[h]),
            .status_o     (status[h])
        );

        assign status_eoc[h] = status[h][31];
        assign code_nz[h]    = |status[h][30:0];
    end

    // Disabled harts do not block EOC; at least one hart must be enabled.
    assign eoc_o       = (|fetch_en_o) && (&(status_eoc | ~fetch_en_o));
    assign exit_fail_o = |(fetch_en_o & status_eoc & code_nz);

    always_comb begin
        rdata_d = '0;
        if (reg_addr_i == ADDR_EOCMASK) begin
            rdata_d = 32'(status_eoc);
        end else if (reg_addr_i == ADDR_IRQEN) begin
            rdata_d = {31'd0, irqen_q};
        end else begin
            for (int h = 0; h < NumHarts; h++) begin
                if (hart_idx == 4'(h)) begin
                    case (reg_off)
                        OFF_BOOTADDR:   rdata_d = boot_addr_o[h];
                        OFF_FETCHEN:    rdata_d = {31'd0, fetch_en_o[h]};
                        OFF_CORESTATUS: rdata_d = status[h];
                        default:        rdata_d = '0;
                    endcase
                end
            end
        end
        if (!reg_req_i || reg_we_i || acc_err) rdata_d = '0;
        ready_d = reg_req_i;
        error_d = reg_req_i && acc_err;
        irqen_d = (wr_ok && reg_addr_i == ADDR_IRQEN) ? reg_wdata_i[0] : irqen_q;
        irq_d   = eoc_o && !eoc_prev_q && irqen_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_en = 1'b0;
        case (state_q)
            SEQ_RESET_WAIT: state_d = (bootmode_i == BOOT_PRELOADED) ? SEQ_AUTO_DELAY : SEQ_RUN;
            SEQ_AUTO_DELAY: begin
                if (cnt_q == DelayLast) begin
                    auto_en = 1'b1;
                    state_d = SEQ_RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SEQ_RUN:  if (eoc_o)  state_d = SEQ_DONE;
            SEQ_DONE: if (!eoc_o) state_d = SEQ_RUN;
            default:  state_d = SEQ_RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
            irqen_q    <= 1'b0;
            eoc_prev_q <= 1'b0;
            irq_q      <= 1'b0;
            cnt_q      <= '0;
            state_q    <= SEQ_RESET_WAIT;
        end else begin
            ready_q    <= ready_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
            irqen_q    <= irqen_d;
            eoc_prev_q <= eoc_o;
            irq_q      <= irq_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
        end
    end

    assign reg_ready_o = ready_q;
    assign reg_error_o = error_q;
    assign reg_rdata_o = rdata_q;
    assign eoc_irq_o   = irq_q;

endmodule

// File: tb/tb_safety_boot_ctrl.sv
// tb/tb_safety_boot_ctrl.sv - randomized and directed self-checking bench for safety_boot_ctrl
module tb_safety_boot_ctrl;

    localparam int NH   = 2;
    localparam int AUTO = 16;
    localparam logic [31:0] DEF_BOOT = 32'h0001_0000;

    logic                 clk = 1'b0;
    logic                 rst_ni = 1'b0;
    logic [1:0]           bootmode = 2'd0;
    logic                 req = 1'b0, we = 1'b0;
    logic [7:0]           addr = 8'h00;
    logic [31:0]          wdata = 32'h0;
    logic                 reg_ready_o, reg_error_o, eoc_o, exit_fail_o, eoc_irq_o;
    logic [31:0]          reg_rdata_o;
    logic [NH-1:0][31:0]  boot_addr_o;
    logic [NH-1:0]        fetch_en_o;

    int checks = 0;
    int errors = 0;

    safety_boot_ctrl #(
        .NumHarts(NH), .DefaultBootAddr(DEF_BOOT), .AutoBootDelay(AUTO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bootmode_i(bootmode),
        .reg_req_i(req), .reg_we_i(we), .reg_addr_i(addr), .reg_wdata_i(wdata),
        .reg_ready_o(reg_ready_o), .reg_rdata_o(reg_rdata_o), .reg_error_o(reg_error_o),
        .boot_addr_o(boot_addr_o), .fetch_en_o(fetch_en_o),
        .eoc_o(eoc_o), .exit_fail_o(exit_fail_o), .eoc_irq_o(eoc_irq_o)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: architectural register contents plus expected response.
    logic [31:0] m_boot [NH];
    logic [31:0] m_stat [NH];
    logic [NH-1:0] m_fen;
    logic        m_irqen, prev_eoc;
    logic        exp_ready, exp_err, exp_irq;
    logic [31:0] exp_rdata;
    int          edges;

    function automatic void model_reset();
        for (int h = 0; h < NH; h++) begin
            m_boot[h] = DEF_BOOT;
            m_stat[h] = 32'h0;
        end
        m_fen = '0; m_irqen = 1'b0; prev_eoc = 1'b0;
        exp_ready = 1'b0; exp_err = 1'b0; exp_irq = 1'b0; exp_rdata = 32'h0;
        edges = 0;
    endfunction

    function automatic logic m_eoc();
        logic any_en = 1'b0, all_done = 1'b1;
        for (int h = 0; h < NH; h++)
            if (m_fen[h]) begin
                any_en = 1'b1;
                if (!m_stat[h][31]) all_done = 1'b0;
            end
        return any_en && all_done;
    endfunction

    function automatic logic m_fail();
        logic f = 1'b0;
        for (int h = 0; h < NH; h++)
            if (m_fen[h] && m_stat[h][31] && m_stat[h][30:0] != 31'd0) f = 1'b1;
        return f;
    endfunction

    function automatic logic m_err(input logic w, input logic [7:0] a);
        if (a[1:0] != 2'b00) return 1'b1;
        if (a[7:4] == 4'hF) return !((a == 8'hF0 && !w) || a == 8'hF4);
        if (int'(a[7:4]) >= NH) return 1'b1;
        return a[3:0] == 4'hC;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        int h = int'(a[7:4]);
        logic [31:0] mask = 32'h0;
        if (a == 8'hF0) begin
            for (int i = 0; i < NH; i++) mask[i] = m_stat[i][31];
            return mask;
        end
        if (a == 8'hF4) return {31'd0, m_irqen};
        case (a[3:0])
            4'h0:    return m_boot[h];
            4'h4:    return {31'd0, m_fen[h]};
            default: return m_stat[h];
        endcase
    endfunction

    function automatic void model_step();
        logic cur, fw;
        int h;
        edges++;
        cur = m_eoc();
        exp_irq = cur && !prev_eoc && m_irqen;
        prev_eoc = cur;
        exp_ready = req; exp_err = 1'b0; exp_rdata = 32'h0; fw = 1'b0;
        if (req) begin
            exp_err = m_err(we, addr);
            if (!we && !exp_err) exp_rdata = m_read(addr);
            if (we && !exp_err) begin
                h = int'(addr[7:4]);
                if (addr == 8'hF4) m_irqen = wdata[0];
                else case (addr[3:0])
                    4'h0:    m_boot[h] = wdata;
                    4'h4:    begin m_fen[h] = wdata[0]; if (h == 0) fw = 1'b1; end
                    default: m_stat[h] = wdata;
                endcase
            end
        end
        // Preloaded boot: hart 0 starts AUTO cycles after leaving the first post-reset cycle.
        if (bootmode == 2'd1 && edges == AUTO + 1 && !fw) m_fen[0] = 1'b1;
    endfunction

    always @(posedge clk) if (rst_ni) model_step();

    always @(negedge clk) begin
        chk("fetch_en", 32'(fetch_en_o), 32'(m_fen));
        for (int h = 0; h < NH; h++) chk("boot_addr", boot_addr_o[h], m_boot[h]);
        chk("eoc", 32'(eoc_o), 32'(m_eoc()));
        chk("exit_fail", 32'(exit_fail_o), 32'(m_fail()));
        chk("eoc_irq", 32'(eoc_irq_o), 32'(exp_irq));
        chk("ready", 32'(reg_ready_o), 32'(exp_ready));
        if (exp_ready) begin
            chk("rdata", reg_rdata_o, exp_rdata);
            chk("error", 32'(reg_error_o), 32'(exp_err));
        end
    end

    task automatic do_reset(input logic [1:0] mode);
        #3 rst_ni = 1'b0;
        req = 1'b0; we = 1'b0;
        model_reset();
        bootmode = mode;
        @(negedge clk);
        chk("rst_fetch_en", 32'(fetch_en_o), 32'h0);
        chk("rst_boot1", boot_addr_o[1], 32'h0001_0000);
        chk("rst_eoc", 32'(eoc_o), 32'h0);
        chk("rst_ready", 32'(reg_ready_o), 32'h0);
        chk("rst_irq", 32'(eoc_irq_o), 32'h0);
        chk("rst_rdata", reg_rdata_o, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;
    endtask

    // Caller must be at a falling edge.
    task automatic acc(input logic w, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        chk("acc_ready", 32'(reg_ready_o), 32'h1);
        rd = reg_rdata_o; er = reg_error_o;
        req = 1'b0;
    endtask

    task automatic check_autoboot();
        for (int k = 1; k <= AUTO + 1; k++) begin
            @(negedge clk);
            chk("autoboot_fen", 32'(fetch_en_o), (k >= AUTO + 1) ? 32'h1 : 32'h0);
        end
    endtask

    logic [3:0] hsel [4] = '{4'h0, 4'h1, 4'h2, 4'hF};
    logic [3:0] osel [6] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h1, 4'h6};

    task automatic rand_phase(input int n);
        logic [31:0] wd;
        for (int i = 0; i < n; i++) begin
            req  = ($urandom_range(3) != 0);
            we   = 1'($urandom_range(1));
            addr = {hsel[$urandom_range(3)], osel[$urandom_range(5)]};
            wd   = $urandom;
            if ($urandom_range(1) == 1) wd = {wd[31], 27'd0, wd[3:0] & (($urandom_range(1) == 1) ? 4'h0 : 4'hF)};
            wdata = wd;
            @(negedge clk);
        end
        req = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          pulses;

    initial begin
        model_reset();
        do_reset(2'd0);

        acc(1'b1, 8'h10, 32'h1C00_0080, rd, er);
        acc(1'b0, 8'h10, 32'h0, rd, er);
        chk("bootaddr1_rd", rd, 32'h1C00_0080);
        chk("bootaddr1_err", 32'(er), 32'h0);

        do_reset(2'd0);
        acc(1'b1, 8'h04, 32'h1, rd, er);
        acc(1'b1, 8'h14, 32'h1, rd, er);
        acc(1'b1, 8'hF4, 32'h1, rd, er);
        acc(1'b1, 8'h08, 32'h8000_0000, rd, er);
        chk("eoc_one_done", 32'(eoc_o), 32'h0);
        acc(1'b1, 8'h18, 32'h8000_0003, rd, er);
        chk("eoc_all_done", 32'(eoc_o), 32'h1);
        chk("exit_fail_set", 32'(exit_fail_o), 32'h1);
        pulses = int'(eoc_irq_o);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            pulses += int'(eoc_irq_o);
        end
        chk("irq_pulses", 32'(pulses), 32'h1);
        acc(1'b0, 8'hF0, 32'h0, rd, er);
        chk("eocmask", rd, 32'h3);
        acc(1'b0, 8'h20, 32'h0, rd, er);
        chk("bad_hart_err", 32'(er), 32'h1);
        chk("bad_hart_rdata", rd, 32'h0);
        acc(1'b0, 8'h06, 32'h0, rd, er);
        chk("misalign_err", 32'(er), 32'h1);
        chk("misalign_rdata", rd, 32'h0);
        acc(1'b1, 8'hF0, 32'h0, rd, er);
        chk("eocmask_wr_err", 32'(er), 32'h1);
        acc(1'b0, 8'hF0, 32'h0, rd, er);
        chk("eocmask_kept", rd, 32'h3);
        acc(1'b1, 8'h04, 32'h0, rd, er);
        acc(1'b0, 8'h08, 32'h0, rd, er);
        chk("status_kept", rd, 32'h8000_0000);

        do_reset(2'd1);
        check_autoboot();

        do_reset(2'd1);
        repeat (AUTO) @(negedge clk);
        acc(1'b1, 8'h04, 32'h0, rd, er);
        chk("auto_override", 32'(fetch_en_o[0]), 32'h0);
        repeat (3) @(negedge clk);
        chk("auto_override_hold", 32'(fetch_en_o[0]), 32'h0);

        do_reset(2'd1);
        repeat (8) @(negedge clk);
        do_reset(2'd1);
        check_autoboot();

        do_reset(2'd0);
        rand_phase(500);
        do_reset(2'd1);
        rand_phase(500);
        do_reset(2'd3);
        rand_phase(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
